// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: trap/return sequencer that owns the machine-mode CSR write port.
// ECALL, EBREAK, MRET and accepted interrupts run a held multi-cycle sequence
// that writes mepc/mcause/mstatus and then issues a one-cycle fetch redirect.
// Outside a sequence, execute-stage CSR writes are forwarded unchanged.
module csr_trap_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           inst_i,
    input  logic [DATA_WIDTH-1:0] inst_addr_i,
    input  logic [7:0]            int_flag_i,
    input  logic                  jump_flag_i,
    input  logic                  ex_csr_we_i,
    input  logic [11:0]           ex_csr_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_csr_wdata_i,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_i,
    input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  hold_o,
    output logic                  int_assert_o,
    output logic [DATA_WIDTH-1:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL  = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] CAUSE_INT    = {1'b1, (DATA_WIDTH-1)'(11)};

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        JUMP,
        R_MSTATUS,
        R_JUMP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;

    logic                  is_ecall, is_ebreak, is_mret, int_req;
    logic                  we_c;
    logic [11:0]           waddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  hold_c, assert_c;
    logic [DATA_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0] trap_mstatus, ret_mstatus;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    // Interrupts wait for a quiet execute slot: no CSR write, no redirect, no trap/return instruction.
    assign int_req   = (int_flag_i != 8'd0) && csr_mstatus_i[3] && !ex_csr_we_i && !jump_flag_i
                       && !is_ecall && !is_ebreak && !is_mret;

    // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and return (MIE<=MPIE, MPIE<=1).
    always_comb begin
        trap_mstatus    = csr_mstatus_i;
        trap_mstatus[7] = csr_mstatus_i[3];
        trap_mstatus[3] = 1'b0;
        ret_mstatus     = csr_mstatus_i;
        ret_mstatus[3]  = csr_mstatus_i[7];
        ret_mstatus[7]  = 1'b1;
    end

    // Next-state, latched trap info and raw port values for the current state.
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        we_c     = 1'b0;
        waddr_c  = 12'd0;
        wdata_c  = '0;
        hold_c   = 1'b0;
        assert_c = 1'b0;
        addr_c   = '0;
        case (state_q)
            IDLE: begin
                we_c    = ex_csr_we_i;
                waddr_c = ex_csr_waddr_i;
                wdata_c = ex_csr_wdata_i;
                if (is_ecall || is_ebreak) begin
                    hold_c  = 1'b1;
                    state_d = W_MEPC;
                    epc_d   = inst_addr_i;
                    cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                end else if (is_mret) begin
                    hold_c  = 1'b1;
                    state_d = R_MSTATUS;
                end else if (int_req) begin
                    hold_c  = 1'b1;
                    state_d = W_MEPC;
                    epc_d   = inst_addr_i;
                    cause_d = CAUSE_INT;
                end
            end
            W_MEPC: begin
                hold_c  = 1'b1;
                we_c    = 1'b1;
                waddr_c = CSR_MEPC;
                wdata_c = epc_q;
                state_d = W_MCAUSE;
            end
            W_MCAUSE: begin
                hold_c  = 1'b1;
                we_c    = 1'b1;
                waddr_c = CSR_MCAUSE;
                wdata_c = cause_q;
                state_d = W_MSTATUS;
            end
            W_MSTATUS: begin
                hold_c  = 1'b1;
                we_c    = 1'b1;
                waddr_c = CSR_MSTATUS;
                wdata_c = trap_mstatus;
                state_d = JUMP;
            end
            JUMP: begin
                hold_c   = 1'b1;
                assert_c = 1'b1;
                addr_c   = csr_mtvec_i;
                state_d  = IDLE;
            end
            R_MSTATUS: begin
                hold_c  = 1'b1;
                we_c    = 1'b1;
                waddr_c = CSR_MSTATUS;
                wdata_c = ret_mstatus;
                state_d = R_JUMP;
            end
            R_JUMP: begin
                hold_c   = 1'b1;
                assert_c = 1'b1;
                addr_c   = csr_mepc_i;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, including the forward path.
    always_comb begin
        csr_we_o     = rst_i & we_c;
        csr_waddr_o  = rst_i ? waddr_c : 12'd0;
        csr_wdata_o  = rst_i ? wdata_c : '0;
        hold_o       = rst_i & hold_c;
        int_assert_o = rst_i & assert_c;
        int_addr_o   = rst_i ? addr_c : '0;
    end

    // State and latched trap registers; reset aborts any sequence in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a schedule-based reference model.
module tb_csr_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i, inst_addr_i;
    logic [7:0]  int_flag_i;
    logic        jump_flag_i, ex_csr_we_i;
    logic [11:0] ex_csr_waddr_i;
    logic [31:0] ex_csr_wdata_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        csr_we_o, hold_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of pending steps of the running sequence.
    // 1=write mepc 2=write mcause 3=write trap mstatus 4=redirect to mtvec
    // 5=write return mstatus 6=redirect to mepc
    int          steps[$];
    logic [31:0] m_epc, m_cause;

    csr_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .int_flag_i(int_flag_i), .jump_flag_i(jump_flag_i), .ex_csr_we_i(ex_csr_we_i),
        .ex_csr_waddr_i(ex_csr_waddr_i), .ex_csr_wdata_i(ex_csr_wdata_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .hold_o(hold_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Which event the current inputs raise in idle: 0 none, 1 ecall, 2 ebreak, 3 mret, 4 interrupt.
    function automatic int event_kind();
        if (inst_i == ECALL)  return 1;
        if (inst_i == EBREAK) return 2;
        if (inst_i == MRET)   return 3;
        if (int_flag_i != 0 && csr_mstatus_i[3] && !ex_csr_we_i && !jump_flag_i) return 4;
        return 0;
    endfunction

    // One clock: compare outputs mid-cycle against the model, then advance the model over the edge.
    task automatic tick();
        logic        e_we, e_hold, e_as;
        logic [11:0] e_wa;
        logic [31:0] e_wd, e_ia, ms;
        int          ev;
        @(negedge clk_i);
        ev = event_kind();
        e_we = 0; e_wa = 0; e_wd = 0; e_hold = 0; e_as = 0; e_ia = 0;
        if (rst_i && steps.size() == 0) begin
            e_we = ex_csr_we_i; e_wa = ex_csr_waddr_i; e_wd = ex_csr_wdata_i;
            e_hold = (ev != 0);
        end else if (rst_i) begin
            e_hold = 1;
            ms = csr_mstatus_i;
            case (steps[0])
                1: begin e_we = 1; e_wa = 12'h341; e_wd = m_epc; end
                2: begin e_we = 1; e_wa = 12'h342; e_wd = m_cause; end
                3: begin e_we = 1; e_wa = 12'h300; e_wd = ms; e_wd[7] = ms[3]; e_wd[3] = 0; end
                4: begin e_as = 1; e_ia = csr_mtvec_i; end
                5: begin e_we = 1; e_wa = 12'h300; e_wd = ms; e_wd[3] = ms[7]; e_wd[7] = 1; end
                default: begin e_as = 1; e_ia = csr_mepc_i; end
            endcase
        end
        check("hold", {31'd0, hold_o}, {31'd0, e_hold});
        check("csr_we", {31'd0, csr_we_o}, {31'd0, e_we});
        check("int_assert", {31'd0, int_assert_o}, {31'd0, e_as});
        if (e_we || !rst_i) begin
            check("csr_waddr", {20'd0, csr_waddr_o}, {20'd0, e_wa});
            check("csr_wdata", csr_wdata_o, e_wd);
        end
        if (e_as || !rst_i) check("int_addr", int_addr_o, e_ia);
        // advance over the rising edge
        if (!rst_i) begin
            steps.delete();
            m_epc = 0; m_cause = 0;
        end else if (steps.size() != 0) begin
            void'(steps.pop_front());
        end else if (ev == 3) begin
            steps = '{5, 6};
        end else if (ev != 0) begin
            steps = '{1, 2, 3, 4};
            m_epc = inst_addr_i;
            m_cause = (ev == 1) ? 32'd11 : (ev == 2) ? 32'd3 : 32'h8000_000B;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        inst_i = NOP; int_flag_i = 0; jump_flag_i = 0; ex_csr_we_i = 0;
        ex_csr_waddr_i = 0; ex_csr_wdata_i = 0;
    endtask

    task automatic idle_n(input int n);
        quiet();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_i = 0; quiet(); inst_addr_i = 0;
        csr_mtvec_i = 32'h80; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h8;
        @(posedge clk_i); #1;
        tick(); tick();
        rst_i = 1;
        idle_n(2);

        // ECALL at 0x100, mtvec 0x80, mstatus 0x8
        inst_i = ECALL; inst_addr_i = 32'h100; tick();
        idle_n(6);
        // MRET with mepc 0x104, mstatus 0x80
        csr_mstatus_i = 32'h80; inst_i = MRET; tick();
        idle_n(4);
        // Interrupt with MIE set, then with MIE clear
        csr_mstatus_i = 32'h8; int_flag_i = 8'h01; inst_addr_i = 32'h200; tick();
        idle_n(6);
        csr_mstatus_i = 32'h0; int_flag_i = 8'h01; tick(); tick();
        // Interrupt deferred behind an execute-stage CSR write
        csr_mstatus_i = 32'h8; int_flag_i = 8'h01;
        ex_csr_we_i = 1; ex_csr_waddr_i = 12'h305; ex_csr_wdata_i = 32'h40; tick();
        ex_csr_we_i = 0; ex_csr_waddr_i = 0; ex_csr_wdata_i = 0; tick();
        idle_n(6);
        // ECALL together with an interrupt; MIE then clear so no second sequence
        inst_i = ECALL; int_flag_i = 8'h04; inst_addr_i = 32'h300; tick();
        inst_i = NOP; csr_mstatus_i = 32'h80;
        for (int i = 0; i < 7; i++) tick();
        // Reset during W_MCAUSE, then forwarding after release
        csr_mstatus_i = 32'h8; quiet(); inst_i = EBREAK; inst_addr_i = 32'h400; tick();
        inst_i = NOP; tick();
        rst_i = 0; tick();
        rst_i = 1; ex_csr_we_i = 1; ex_csr_waddr_i = 12'h305; ex_csr_wdata_i = 32'h1234; tick();
        idle_n(3);

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 19);
            inst_i = (r == 0) ? ECALL : (r == 1) ? EBREAK : (r == 2) ? MRET : $urandom();
            inst_addr_i    = $urandom() & 32'hFFFF_FFFC;
            int_flag_i     = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'd0;
            jump_flag_i    = ($urandom_range(0, 9) == 0);
            ex_csr_we_i    = (r > 2) && ($urandom_range(0, 9) < 3);
            ex_csr_waddr_i = 12'($urandom());
            ex_csr_wdata_i = $urandom();
            csr_mtvec_i    = $urandom();
            csr_mepc_i     = $urandom();
            csr_mstatus_i  = $urandom();
            rst_i          = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and return sequencer for the machine-mode CSR file. It sits beside the execute stage and owns the single CSR write port. ECALL, EBREAK, MRET and external-interrupt events are turned into a held, multi-cycle sequence that updates mepc, mcause and mstatus and then redirects fetch. Outside a sequence, execute-stage CSR writes (CSRRW/S/C and immediate forms) pass straight through to the CSR file.

## Interface
- DATA_WIDTH, 32: CSR and address width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- inst_i  in  32  instruction currently in execute.
- inst_addr_i  in  32  PC of inst_i.
- int_flag_i  in  8  external interrupt lines, level; any nonzero bit is an interrupt request.
- jump_flag_i  in  1  execute stage is redirecting this cycle.
- ex_csr_we_i  in  1  execute-stage CSR write enable.
- ex_csr_waddr_i  in  12  execute-stage CSR address.
- ex_csr_wdata_i  in  32  execute-stage CSR write data.
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  current CSR values.
- csr_we_o  out  1  CSR file write enable.
- csr_waddr_o  out  12  CSR file write address.
- csr_wdata_o  out  32  CSR file write data.
- hold_o  out  1  stalls fetch, decode and execute.
- int_assert_o  out  1  one-cycle fetch redirect.
- int_addr_o  out  32  redirect target.

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, JUMP, R_MSTATUS, R_JUMP.
- Instruction decode uses full 32-bit matches:
  - ECALL = 0x00000073
  - EBREAK = 0x00100073
  - MRET = 0x30200073
- Event priority in IDLE, highest first:
  - ECALL/EBREAK
  - MRET
  - interrupt
- An interrupt is accepted only when all of the following hold:
  - int_flag_i != 0
  - csr_mstatus_i[3] (MIE) = 1
  - ex_csr_we_i = 0
  - jump_flag_i = 0
  - inst_i is not ECALL/EBREAK/MRET
- On acceptance in IDLE, the block latches:
  - epc_q = inst_addr_i. An interrupted instruction has not executed and is re-executed on return.
  - cause_q: ECALL = 32'd11; EBREAK = 32'd3; interrupt = 32'h8000000B.
- Trap path: IDLE → W_MEPC → W_MCAUSE → W_MSTATUS → JUMP → IDLE.
  - W_MEPC writes 0x341 with epc_q.
  - W_MCAUSE writes 0x342 with cause_q.
  - W_MSTATUS writes 0x300 with csr_mstatus_i, where bit7 (MPIE) takes old bit3 and bit3 (MIE) = 0.
  - JUMP: int_assert_o = 1, int_addr_o = csr_mtvec_i.
- Return path: IDLE → R_MSTATUS → R_JUMP → IDLE.
  - R_MSTATUS writes 0x300 with bit3 = old bit7 and bit7 = 1.
  - R_JUMP: int_assert_o = 1, int_addr_o = csr_mepc_i.
- CSR port mux:
  - In non-IDLE states the sequencer drives the port.
  - In IDLE the ex_csr_* inputs are forwarded combinationally.
  - Execute is held for the whole sequence, so no conflict is possible.
- Events arriving outside IDLE are ignored. A level interrupt that is still asserted is re-evaluated in IDLE.

## Timing
- Reset (rst_i = 0 at an edge):
  - state = IDLE, epc_q = 0, cause_q = 0.
  - While rst_i = 0, all outputs are forced to 0, including the forward path.
  - Reset mid-sequence aborts it with no redirect and no further CSR writes.
- hold_o:
  - Combinational 1 in the IDLE detect cycle.
  - 1 in every non-IDLE state.
  - Drops in the cycle after JUMP/R_JUMP.
- Trap latency: detect at cycle 0; writes at cycles 1, 2, 3; redirect at cycle 4; IDLE at cycle 5. Total 5 held cycles.
- Return latency: detect at cycle 0; mstatus write at cycle 1; redirect at cycle 2. Total 3 held cycles.
- int_assert_o lasts exactly one cycle per sequence.
- csr_we_o asserts exactly once per W_*/R_MSTATUS state.
- The detect cycle itself produces no CSR write: csr_we_o = 0 for ECALL/EBREAK/MRET, since their ex_csr_we_i is 0.
- No combinational path from int_flag_i to csr_*_o.

## Test plan
- ECALL at PC 0x100, mtvec = 0x80, mstatus = 0x8:
  - mepc←0x100, mcause←11, mstatus←0x80, each on its own cycle.
  - int_assert_o with addr 0x80 at cycle 4.
  - hold_o high on cycles 0–4.
- MRET with mepc = 0x104, mstatus = 0x80:
  - mstatus←0x88 at cycle 1.
  - redirect to 0x104 at cycle 2.
  - IDLE at cycle 3.
- int_flag_i = 0x01, MIE = 1, PC 0x200:
  - mcause←0x8000000B, mepc←0x200.
  - Repeat with MIE = 0 → no sequence, hold_o = 0.
- Interrupt with ex_csr_we_i = 1 (addr 0x305, data 0x40):
  - The write is forwarded unchanged and the interrupt is deferred.
  - Next cycle with ex_csr_we_i = 0 → trap starts.
- ECALL and int_flag_i together → mcause = 11; no second sequence while MIE = 0.
- rst_i low during W_MCAUSE:
  - All outputs 0, no redirect.
  - After release, state is IDLE and forwarding works.
